// File: rtl/sorting_insert_if.sv
// Avalon-ST style stream bundle shared by the sorter's sink and source sides.
// The slave side leaves out error, which a sink has no use for.
interface sorting_insert_if #(
    parameter int unsigned DWIDTH = 16
);
    logic [DWIDTH-1:0] data;
    logic              startofpacket;
    logic              endofpacket;
    logic              valid;
    logic              ready;
    logic              error;

    modport master (
        output data, startofpacket, endofpacket, valid, error,
        input  ready
    );

    modport slave (
        input  data, startofpacket, endofpacket, valid,
        output ready
    );
endinterface

// File: rtl/sorting_insert.sv
// Streaming packet sorter: every accepted word is inserted into sorted position in the
// cycle it arrives, so the sorted packet can be replayed right after its EOP beat.
module sorting_insert #(
    parameter int unsigned  DWIDTH      = 16,
    parameter int unsigned  MAX_PKT_LEN = 16,
    localparam int unsigned CWIDTH      = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             dir_i,
    sorting_insert_if.slave  snk,
    sorting_insert_if.master src
);

    typedef enum logic [1:0] {StIdle, StFill, StSend} state_e;

    state_e            state_q, state_d;
    logic [CWIDTH-1:0] count_q, count_d;
    logic [CWIDTH-1:0] rd_q, rd_d;
    logic              ovf_q, ovf_d;
    logic              dir_q, dir_d;
    logic              ready_q, ready_d;
    logic [DWIDTH-1:0] mem_q [MAX_PKT_LEN];
    logic [DWIDTH-1:0] mem_d [MAX_PKT_LEN];

    logic [CWIDTH-1:0] ins_pos;
    logic [DWIDTH-1:0] rd_data;
    logic              accept;
    logic              in_send;
    logic              is_last;

    assign accept  = snk.valid && ready_q;
    assign in_send = (state_q == StSend);
    assign is_last = (rd_q == count_q - CWIDTH'(1));

    // Stored words stay sorted, so the kept slots form a prefix and their count is the slot.
    always_comb begin
        ins_pos = '0;
        for (int i = 0; i < int'(MAX_PKT_LEN); i++) begin
            if (CWIDTH'(i) < count_q) begin
                if (dir_q ? (mem_q[i] >= snk.data) : (mem_q[i] <= snk.data)) begin
                    ins_pos = ins_pos + CWIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        rd_data = mem_q[0];
        for (int i = 0; i < int'(MAX_PKT_LEN); i++) begin
            if (CWIDTH'(i) == rd_q) begin
                rd_data = mem_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rd_d    = rd_q;
        ovf_d   = ovf_q;
        dir_d   = dir_q;
        mem_d   = mem_q;

        unique case (state_q)
            StIdle, StFill: begin
                if (accept && snk.startofpacket) begin
                    // A new SOP always starts a fresh packet, abandoning any partial one.
                    dir_d    = dir_i;
                    mem_d[0] = snk.data;
                    count_d  = CWIDTH'(1);
                    ovf_d    = 1'b0;
                    rd_d     = '0;
                    state_d  = snk.endofpacket ? StSend : StFill;
                end else if (accept && (state_q == StFill)) begin
                    if (count_q < CWIDTH'(MAX_PKT_LEN)) begin
                        mem_d[0] = (ins_pos == '0) ? snk.data : mem_q[0];
                        for (int i = 1; i < int'(MAX_PKT_LEN); i++) begin
                            if (CWIDTH'(i) == ins_pos) begin
                                mem_d[i] = snk.data;
                            end else if (CWIDTH'(i) > ins_pos) begin
                                mem_d[i] = mem_q[i-1];
                            end
                        end
                        count_d = count_q + CWIDTH'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (snk.endofpacket) begin
                        state_d = StSend;
                    end
                end
            end
            StSend: begin
                if (src.ready) begin
                    if (is_last) begin
                        rd_d    = '0;
                        state_d = StIdle;
                    end else begin
                        rd_d = rd_q + CWIDTH'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        ready_d = (state_d != StSend);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= StIdle;
            count_q <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
            dir_q   <= 1'b0;
            ready_q <= 1'b0;
            for (int i = 0; i < int'(MAX_PKT_LEN); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            ovf_q   <= ovf_d;
            dir_q   <= dir_d;
            ready_q <= ready_d;
            mem_q   <= mem_d;
        end
    end

    // rd is held at 0 outside SEND, so rd_data shows mem[0] there.
    assign snk.ready         = ready_q;
    assign src.data          = rd_data;
    assign src.valid         = in_send;
    assign src.startofpacket = in_send && (rd_q == '0);
    assign src.endofpacket   = in_send && is_last;
    assign src.error         = in_send && is_last && ovf_q;

endmodule

// File: doc/sorting_insert.md
# sorting_insert

Streaming packet sorter with Avalon-ST sink and source. It is the parametrised successor to the bubble-sort packet sorter: each incoming word is placed into a register array in sorted position in the same cycle it is accepted, so the packet is sorted by the time its last word arrives. Per-packet ascending or descending order is selectable. The block also adds source backpressure, truncation of oversize packets with error reporting, and mid-packet restart on a new start-of-packet.

## Interface
- DWIDTH, 16: data word width; words are compared as unsigned values.
- MAX_PKT_LEN, 16: storage depth in words, minimum 1.
- CWIDTH, $clog2(MAX_PKT_LEN+1): width of the word counter and read pointer; derived, do not override.

Ports:
- clk_i  in  1  the block's single clock.
- arstn_i  in  1  reset; asynchronous and active-low.
- dir_i  in  1  sort order, sampled on the start-of-packet beat: 0 = ascending, 1 = descending.
- snk_data_i  in  DWIDTH  input word.
- snk_startofpacket_i  in  1  start of packet (SOP).
- snk_endofpacket_i  in  1  end of packet (EOP).
- snk_valid_i  in  1  input beat valid.
- snk_ready_o  out  1  sink can accept a beat.
- src_data_o  out  DWIDTH  sorted output word.
- src_startofpacket_o  out  1  first output word.
- src_endofpacket_o  out  1  last output word.
- src_valid_o  out  1  output beat valid.
- src_error_o  out  1  asserted on the EOP beat when the packet was truncated.
- src_ready_i  in  1  downstream accepts the beat.

## Operation
- A beat is accepted when snk_valid_i && snk_ready_o. A beat is transferred out when src_valid_o && src_ready_i.
- State IDLE:
  - snk_ready_o = 1.
  - Accepted beat with SOP: latch dir_i, store the word at index 0, set count = 1, clear the overflow flag. Go to SEND if EOP is also set, otherwise go to FILL.
  - Accepted beat without SOP: discarded; state unchanged.
- State FILL:
  - snk_ready_o = 1.
  - Accepted beat with SOP: the current packet is abandoned. Restart exactly as the IDLE SOP case, using the new word.
  - Accepted beat without SOP and count < MAX_PKT_LEN: insert the word and increment count.
  - Accepted beat without SOP and count == MAX_PKT_LEN: drop the word and set the overflow flag.
  - An accepted EOP beat goes to SEND after the insert or drop above.
- Insertion of new word x:
  - Per slot i < count: keep[i] = (mem[i] <= x) for ascending, or (mem[i] >= x) for descending.
  - p = number of set keep bits.
  - Slots i >= p move to i+1, then mem[p] = x. All of this happens in one cycle.
  - The compare rule keeps equal values in arrival order, so the sort is stable.
- State SEND:
  - snk_ready_o = 0; the read pointer rd starts at 0.
  - Outputs: src_valid_o = 1, src_data_o = mem[rd], src_startofpacket_o = (rd == 0), src_endofpacket_o = (rd == count-1), src_error_o = overflow flag && EOP.
  - rd increments on each transfer. The transfer of the EOP beat moves the block to IDLE.
- Output signals other than data are driven 0 outside SEND. src_data_o outside SEND shows mem[0] and carries no meaning.

## Timing
- Reset (arstn_i low): state IDLE, count, rd, overflow flag and all mem entries cleared, every output 0. snk_ready_o is driven by a ready flop that is 0 in reset and sets on the first clock edge after release.
- Input throughput: 1 word per cycle while in IDLE or FILL.
- Latency: if the EOP beat is accepted at edge N, the first output beat is valid in the cycle after edge N.
- Output throughput: 1 word per cycle while src_ready_i = 1.
- Source handshake:
  - With src_ready_i = 0, the output data and flags hold stable.
  - src_valid_o never drops without a transfer while in SEND.
- Return to IDLE: after the EOP transfer at edge M, snk_ready_o = 1 in the cycle after edge M.
- Width rules:
  - count saturates at MAX_PKT_LEN; rd never exceeds count-1.
  - Comparison is unsigned over the full DWIDTH.
- Simultaneous SOP and EOP on one beat: a 1-word packet.
- Reset asserted mid-FILL or mid-SEND: the packet is discarded immediately and all outputs drop asynchronously.

## Test plan
- Ascending: MAX_PKT_LEN=8, dir=0, input 5,3,9,1 -> output 1,3,5,9. SOP on 1, EOP on 9, src_error_o = 0, first valid 1 cycle after the EOP beat.
- Descending with duplicates: dir=1, input 2,7,0,7,2 -> output 7,7,2,2,0. snk_ready_o = 0 throughout SEND.
- Single word: one beat 0xA5 with SOP+EOP -> one output beat 0xA5 with SOP and EOP both set. snk_ready_o = 1 again the cycle after the transfer.
- Overflow: MAX_PKT_LEN=4, input 8,6,4,2,1,0 (EOP on 0) -> output 2,4,6,8 with src_error_o = 1 on the 8 beat only.
- Backpressure and restart:
  - src_ready_i pattern 1,0,0,1,0,1 during SEND -> no loss or duplication, and data holds while not ready.
  - SOP mid-FILL after 3,2 then 9,4(EOP) -> output 4,9.
- Reset mid-SEND: assert arstn_i low after 2 of 4 beats -> all outputs 0 at once. A next packet 3,1 -> output 1,3 with correct SOP and EOP.
